// File: rtl/alu_sequencer.sv
// alu_sequencer: three-cycle command sequencer that feeds an external ALU and writes results to r0..r3.
module alu_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [1:0] cmd_rd,
    input  logic [1:0] cmd_rs,
    input  logic [1:0] cmd_rt,
    input  logic       cmd_imm_en,
    input  logic [7:0] cmd_imm,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_sel,
    input  logic [7:0] alu_f,
    input  logic       alu_ovf,
    input  logic       alu_take_branch,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_branch,
    output logic       ovf_sticky,
    input  logic       ovf_clr,
    input  logic [1:0] dbg_addr,
    output logic [7:0] dbg_data
);
    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
    state_t state_q, state_d;
    logic [3:0][7:0] regs_q, regs_d;
    logic [7:0] a_q, a_d, b_q, b_d, data_q, data_d;
    logic [2:0] sel_q, sel_d;
    logic [1:0] rd_q, rd_d;
    logic br_q, br_d, ovf_q, ovf_d;
    logic accept, exec, wb, is_cmp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (cmd_valid && cmd_ready) ? EXEC : IDLE;
            EXEC:    state_d = WB;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == IDLE);
        rsp_valid = (state_q == WB);
        accept    = cmd_valid && cmd_ready;
        exec      = (state_q == EXEC);
        wb        = rsp_valid;
    end

    // Ops 6 and 7 are compares: they report a branch flag but never write back.
    assign is_cmp = &sel_q[2:1];

    always_comb begin
        regs_d = regs_q;
        a_d    = a_q;
        b_d    = b_q;
        sel_d  = sel_q;
        rd_d   = rd_q;
        data_d = data_q;
        br_d   = br_q;
        ovf_d  = (exec && sel_q == 3'd0 && alu_ovf) ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
        if (accept) begin
            a_d   = regs_q[cmd_rs];
            b_d   = cmd_imm_en ? cmd_imm : regs_q[cmd_rt];
            sel_d = cmd_op;
            rd_d  = cmd_rd;
        end
        if (exec) begin
            data_d = alu_f;
            br_d   = is_cmp && alu_take_branch;
        end
        if (wb && !is_cmp) regs_d[rd_q] = data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sel_q  <= '0;
            rd_q   <= '0;
            data_q <= '0;
            br_q   <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            regs_q <= regs_d;
            a_q    <= a_d;
            b_q    <= b_d;
            sel_q  <= sel_d;
            rd_q   <= rd_d;
            data_q <= data_d;
            br_q   <= br_d;
            ovf_q  <= ovf_d;
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_sel    = sel_q;
    assign rsp_data   = data_q;
    assign rsp_branch = br_q;
    assign ovf_sticky = ovf_q;
    assign dbg_data   = regs_q[dbg_addr];
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed table, corner sequences and random commands checked against a reference model.
module tb_alu_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = '0;
    logic [1:0] cmd_rd = '0, cmd_rs = '0, cmd_rt = '0;
    logic       cmd_imm_en = 1'b0;
    logic [7:0] cmd_imm = '0;
    logic [7:0] alu_a, alu_b, alu_f;
    logic [2:0] alu_sel;
    logic       alu_ovf, alu_take_branch;
    logic       rsp_valid, rsp_branch, ovf_sticky;
    logic [7:0] rsp_data, dbg_data;
    logic       ovf_clr = 1'b0;
    logic [1:0] dbg_addr = '0;

    int errors = 0;
    int checks = 0;
    logic [7:0] ref_r [4];
    logic       ref_ovf;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt),
        .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm), .alu_a(alu_a), .alu_b(alu_b),
        .alu_sel(alu_sel), .alu_f(alu_f), .alu_ovf(alu_ovf), .alu_take_branch(alu_take_branch),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_branch(rsp_branch),
        .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Returns {signed add overflow, compare result, result byte}.
    function automatic logic [9:0] alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] f;
        logic br, ov;
        f = '0; br = 1'b0; ov = 1'b0;
        case (op)
            3'd0: begin f = a + b; ov = (a[7] == b[7]) && (f[7] != a[7]); end
            3'd1: f = ~b;
            3'd2: f = a & b;
            3'd3: f = a | b;
            3'd4: f = a >> 1;
            3'd5: f = a << 1;
            3'd6: begin br = (a == b); f = {7'd0, br}; end
            default: begin br = (a != b); f = {7'd0, br}; end
        endcase
        return {ov, br, f};
    endfunction

    // External ALU: branch and overflow carry junk on ops where they must be ignored.
    always_comb begin
        logic [9:0] r;
        r = alu(alu_sel, alu_a, alu_b);
        alu_f           = r[7:0];
        alu_take_branch = r[8] | (alu_sel < 3'd6 && alu_a[0]);
        alu_ovf         = r[9] | (alu_sel != 3'd0 && alu_b[0]);
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs, input logic [1:0] rt,
                       input logic ie, input logic [7:0] imm, input logic clr,
                       output logic [7:0] od, output logic ob, output logic oo, output logic [7:0] oreg);
        logic [9:0] m;
        int w;
        m = alu(op, ref_r[rs], ie ? imm : ref_r[rt]);
        @(negedge clk);
        w = 0;
        while (!cmd_ready && w < 10) begin @(negedge clk); w++; end
        chk("ready_wait", 8'(cmd_ready), 8'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_rt = rt;
        cmd_imm_en = ie; cmd_imm = imm; ovf_clr = clr;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("ready_exec", 8'(cmd_ready), 8'd0);
        @(posedge clk); #1;
        od = rsp_data; ob = rsp_branch; oo = ovf_sticky;
        ovf_clr = 1'b0;
        ref_ovf = (op == 3'd0 && m[9]) ? 1'b1 : (clr ? 1'b0 : ref_ovf);
        chk("rsp_valid_wb", 8'(rsp_valid), 8'd1);
        chk("rsp_data", rsp_data, m[7:0]);
        chk("rsp_branch", 8'(rsp_branch), 8'(op >= 3'd6 ? m[8] : 1'b0));
        chk("ovf_sticky", 8'(ovf_sticky), 8'(ref_ovf));
        @(posedge clk); #1;
        chk("rsp_valid_after", 8'(rsp_valid), 8'd0);
        chk("alu_sel_hold", 8'(alu_sel), 8'(op));
        if (op < 3'd6) ref_r[rd] = m[7:0];
        dbg_addr = rd; #1;
        oreg = dbg_data;
        chk("reg_write", dbg_data, ref_r[rd]);
    endtask

    typedef struct {
        logic [2:0] op;
        logic [1:0] rd, rs, rt;
        logic       ie;
        logic [7:0] imm, d;
        logic       br, ov;
        logic [7:0] rv;
    } vec_t;

    initial begin
        vec_t tbl [7];
        logic [7:0] od, oreg;
        logic ob, oo;
        int cyc, n;
        int acc [2];
        tbl[0] = '{3'd0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h55, 8'h55, 1'b0, 1'b0, 8'h55};
        tbl[1] = '{3'd0, 2'd2, 2'd1, 2'd0, 1'b1, 8'h55, 8'hAA, 1'b0, 1'b1, 8'hAA};
        tbl[2] = '{3'd6, 2'd3, 2'd2, 2'd0, 1'b1, 8'hAA, 8'h01, 1'b1, 1'b1, 8'h00};
        tbl[3] = '{3'd7, 2'd3, 2'd2, 2'd0, 1'b1, 8'hAA, 8'h00, 1'b0, 1'b1, 8'h00};
        tbl[4] = '{3'd1, 2'd3, 2'd0, 2'd0, 1'b1, 8'hC5, 8'h3A, 1'b0, 1'b1, 8'h3A};
        tbl[5] = '{3'd2, 2'd0, 2'd3, 2'd0, 1'b1, 8'h0F, 8'h0A, 1'b0, 1'b1, 8'h0A};
        tbl[6] = '{3'd3, 2'd0, 2'd0, 2'd1, 1'b0, 8'h00, 8'h5F, 1'b0, 1'b1, 8'h5F};
        for (int i = 0; i < 4; i++) ref_r[i] = '0;
        ref_ovf = 1'b0;

        #3;
        chk("rst_ready", 8'(cmd_ready), 8'd1);
        chk("rst_rsp_valid", 8'(rsp_valid), 8'd0);
        chk("rst_alu_a", alu_a, 8'd0);
        chk("rst_ovf", 8'(ovf_sticky), 8'd0);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i); #1;
            chk("rst_reg", dbg_data, 8'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run(tbl[i].op, tbl[i].rd, tbl[i].rs, tbl[i].rt, tbl[i].ie, tbl[i].imm, 1'b0, od, ob, oo, oreg);
            chk($sformatf("tbl%0d_data", i), od, tbl[i].d);
            chk($sformatf("tbl%0d_br", i), 8'(ob), 8'(tbl[i].br));
            chk($sformatf("tbl%0d_ovf", i), 8'(oo), 8'(tbl[i].ov));
            chk($sformatf("tbl%0d_reg", i), oreg, tbl[i].rv);
        end

        // Plain clear, then clear coinciding with an overflowing add: set wins.
        run(3'd3, 2'd0, 2'd0, 2'd0, 1'b1, 8'h00, 1'b1, od, ob, oo, oreg);
        chk("ovf_cleared", 8'(oo), 8'd0);
        run(3'd0, 2'd2, 2'd1, 2'd0, 1'b1, 8'h55, 1'b1, od, ob, oo, oreg);
        chk("ovf_set_wins", 8'(oo), 8'd1);

        for (int i = 0; i < 40; i++)
            run(3'($urandom_range(7, 0)), 2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)),
                2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)), 8'($urandom),
                ($urandom_range(3, 0) == 0), od, ob, oo, oreg);

        // Reset during EXEC aborts the operation.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd3; cmd_rd = 2'd1; cmd_rs = 2'd0; cmd_imm_en = 1'b1; cmd_imm = 8'hFF;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rst_n = 1'b0; #2;
        chk("abort_ready", 8'(cmd_ready), 8'd1);
        chk("abort_valid", 8'(rsp_valid), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) ref_r[i] = '0;
        ref_ovf = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("abort_no_pulse", 8'(rsp_valid), 8'd0);
        end
        dbg_addr = 2'd1; #1;
        chk("abort_r1", dbg_data, 8'h00);

        // Back-to-back commands with cmd_valid held high.
        run(3'd0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h9A, 1'b0, od, ob, oo, oreg);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd5; cmd_rd = 2'd1; cmd_rs = 2'd1; cmd_imm_en = 1'b0;
        cyc = 0; n = 0; acc[0] = 0; acc[1] = 0;
        while (n < 2 && cyc < 20) begin
            if (cmd_ready) begin
                @(posedge clk); #1;
                acc[n] = cyc; n++;
                if (n == 1) begin cmd_op = 3'd4; cmd_rd = 2'd2; cmd_rs = 2'd1; end
                else cmd_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        cmd_valid = 1'b0;
        chk("b2b_accepts", 8'(n), 8'd2);
        chk("b2b_spacing", 8'(acc[1] - acc[0]), 8'd3);
        repeat (3) @(posedge clk);
        #1;
        dbg_addr = 2'd1; #1;
        chk("b2b_r1", dbg_data, 8'h34);
        dbg_addr = 2'd2; #1;
        chk("b2b_r2", dbg_data, 8'h1A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have no parameters; datapath width is fixed at 8 bits and there are 4 internal registers r0..r3.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 cmd_valid  in  1  a command is presented.
REQ-006 cmd_ready  out  1  the block can accept a command; equals (state==IDLE).
REQ-007 cmd_op  in  3  ALU select: 0 add, 1 not b, 2 and, 3 or, 4 shr a, 5 shl a, 6 eq, 7 neq.
REQ-008 cmd_rd, cmd_rs, cmd_rt  in  2 each  destination register, A-source register and B-source register.
REQ-009 cmd_imm_en, cmd_imm  in  1, 8  when cmd_imm_en=1, B comes from cmd_imm instead of r[cmd_rt].
REQ-010 alu_a, alu_b  out  8 each  registered operands to the external ALU.
REQ-011 alu_sel  out  3  registered select to the external ALU.
REQ-012 alu_f, alu_ovf, alu_take_branch  in  8, 1, 1  combinational ALU results.
REQ-013 rsp_valid, rsp_data, rsp_branch  out  1, 8, 1  one-cycle result pulse; result byte; branch flag.
REQ-014 ovf_sticky, ovf_clr  out 1, in 1  accumulated add-overflow flag and its synchronous clear.
REQ-015 dbg_addr, dbg_data  in 2, out 8  combinational read of r[dbg_addr].

Function
REQ-016 The FSM SHALL have states IDLE, EXEC and WB, with transitions IDLE->EXEC on cmd_valid&cmd_ready, EXEC->WB always, and WB->IDLE always.
REQ-017 On accept at edge k: latch alu_a=r[cmd_rs], alu_b=(cmd_imm_en?cmd_imm:r[cmd_rt]), alu_sel=cmd_op, rd; registers are read with their pre-edge values.
REQ-018 At edge k+1 (EXEC end), the block SHALL capture alu_f into rsp_data and alu_take_branch into rsp_branch, and go to WB.
REQ-019 During the WB cycle (between k+1 and k+2), rsp_valid SHALL be 1 for exactly one cycle; there is no backpressure.
REQ-020 At edge k+2, the block SHALL write r[rd]=rsp_data only for ops 0..5; ops 6 and 7 SHALL NOT write any register.
REQ-021 Throughput SHALL be one command per 3 cycles; cmd_ready is 0 during EXEC and WB, and commands presented then are held off, not dropped.
REQ-022 A command accepted at k+3 SHALL observe a write made at k+2, so no hazard stall is needed.
REQ-023 alu_a, alu_b and alu_sel SHALL hold their values through WB and until the next accept.
REQ-024 ovf_sticky SHALL be set at the EXEC-end edge when alu_sel==0 and alu_ovf==1; alu_ovf SHALL be ignored for all other ops.
REQ-025 ovf_clr SHALL clear ovf_sticky at the edge; if set and clear coincide, set wins.
REQ-026 rsp_branch SHALL be 0 for ops 0..5 even if alu_take_branch glitches.
REQ-027 dbg_data SHALL reflect the write on the edge after WB and SHALL have no side effects.

Reset
REQ-028 rst_n low SHALL immediately force: state IDLE; r0..r3=0; alu_a=alu_b=0; alu_sel=0; rsp_valid=0; rsp_data=0; rsp_branch=0; ovf_sticky=0.
REQ-029 cmd_ready SHALL be 1 during and after reset.
REQ-030 A reset asserted in EXEC or WB SHALL abort the operation: no register write, and no rsp_valid pulse after release.
REQ-031 The first accept SHALL be possible on the first rising edge with rst_n high.

Verification
REQ-032 After reset, add r1 = r0 + imm 0x55 -> rsp_valid at k+2 with rsp_data=0x55, r1=0x55, ovf_sticky=0.
REQ-033 With r1=0x55, add r2 = r1 + imm 0x55 -> rsp_data=0xAA, ovf_sticky=1; then raise ovf_clr in the EXEC-end cycle of another overflowing add -> ovf_sticky stays 1.
REQ-034 With r2=0xAA, op6 r2 vs imm 0xAA, rd=3 -> rsp_data=0x01, rsp_branch=1, r3 unchanged at 0; op7 with the same operands -> rsp_data=0x00, rsp_branch=0.
REQ-035 cmd_valid held high for two commands, "shl r1 = imm-loaded 0x9A" then "shr r2 = r1" -> accepts exactly 3 cycles apart, r1=0x34, r2=0x1A.
REQ-036 rst_n pulsed low during EXEC of "or r1 = r0 | imm 0xFF" -> r1 stays 0x00, no rsp_valid, and cmd_ready=1 on release.
REQ-037 op1 with imm 0xC5 to r3 -> rsp_data=0x3A, and dbg_addr=3 reads 0x3A after WB.
